// File: rtl/serv_ibus_pkg.sv
// rtl/serv_ibus_pkg.sv - shared types and constants for the SERV ibus responder
//
// Purpose : FSM state type, Wishbone word width and latency-counter sizing
//           shared by the responder top, its hit buffer and the bus interface.
// Ports   : none (package).
package serv_ibus_pkg;

    localparam int WB_WORD_W  = 32;
    localparam int RD_LAT_MAX = 4;
    // Counter only has to reach RD_LAT_MAX-1, one spare bit keeps it simple.
    localparam int LAT_CNT_W  = $clog2(RD_LAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/serv_ibus_if.sv
// rtl/serv_ibus_if.sv - Wishbone instruction-bus interface between aligner and responder
//
// Purpose : bundles the ibus request/response signals.
// Signals : adr  byte fetch address (master -> slave)
//           cyc  request valid, held until ack (master -> slave)
//           ack  one-cycle response strobe (slave -> master)
//           rdt  fetched word, valid with ack (slave -> master)
//           err  out-of-range fetch, valid with ack (slave -> master)
interface serv_ibus_if;
    import serv_ibus_pkg::*;

    logic [31:0]           adr;
    logic                  cyc;
    logic                  ack;
    logic [WB_WORD_W-1:0]  rdt;
    logic                  err;

    modport master (output adr, output cyc, input ack, input rdt, input err);
    modport slave  (input adr, input cyc, output ack, output rdt, output err);

endinterface

// File: rtl/serv_ibus_hit_buf.sv
// rtl/serv_ibus_hit_buf.sv - one-entry tag/data buffer for repeated ibus fetches
//
// Purpose : remembers the last word read from SRAM so the aligner's repeated
//           adr+4 refetch can be answered without another SRAM access.
// Ports   : clk, rst_n      clock, asynchronous active-low reset
//           i_inval         clears the entry at the next edge (wins over fill)
//           i_fill          load i_fill_tag/i_fill_data and mark valid
//           i_lookup_tag    word index being looked up
//           o_hit           entry valid and tag matches i_lookup_tag
//           o_data          buffered word
module serv_ibus_hit_buf
    import serv_ibus_pkg::*;
#(
    parameter int unsigned TAG_W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_inval,
    input  logic                  i_fill,
    input  logic [TAG_W-1:0]      i_fill_tag,
    input  logic [WB_WORD_W-1:0]  i_fill_data,
    input  logic [TAG_W-1:0]      i_lookup_tag,
    output logic                  o_hit,
    output logic [WB_WORD_W-1:0]  o_data
);

    logic                  valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q,   tag_d;
    logic [WB_WORD_W-1:0]  data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (i_inval) begin
            // Invalidation beats a coincident fill so stale code is never kept.
            valid_d = 1'b0;
        end else if (i_fill) begin
            valid_d = 1'b1;
            tag_d   = i_fill_tag;
            data_d  = i_fill_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign o_hit  = valid_q && (tag_q == i_lookup_tag);
    assign o_data = data_q;

endmodule

// File: rtl/serv_ibus_responder.sv
// rtl/serv_ibus_responder.sv - Wishbone ibus responder reading a synchronous SRAM
//
// Purpose : answers word fetches from the SERV misaligned-fetch aligner. Range
//           checks the address, reads SRAM with RD_LAT-cycle latency and returns
//           a one-cycle ack with rdt/err. With SERV_IBUS_HIT_BUF_EN defined a
//           one-word hit buffer answers repeated fetches in one cycle; without
//           it every in-range fetch reads SRAM and i_ibus_inval is ignored.
// Ports   : clk, rst_n      clock, asynchronous active-low reset
//           ibus            serv_ibus_if slave (adr, cyc -> ack, rdt, err)
//           i_ibus_inval    clears the hit buffer
//           o_mem_en        SRAM read enable, one-cycle pulse
//           o_mem_addr      SRAM word address
//           i_mem_rdata     SRAM data, sampled RD_LAT edges after o_mem_en rises
module serv_ibus_responder
    import serv_ibus_pkg::*;
#(
    parameter int unsigned MEM_AW    = 10,
    parameter int unsigned RD_LAT    = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serv_ibus_if.slave            ibus,
    input  logic                  i_ibus_inval,
    output logic                  o_mem_en,
    output logic [MEM_AW-1:0]     o_mem_addr,
    input  logic [WB_WORD_W-1:0]  i_mem_rdata
);

    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(RD_LAT - 1);

    state_e                state_q,    state_d;
    logic                  ack_q,      ack_d;
    logic                  err_q,      err_d;
    logic [WB_WORD_W-1:0]  rdt_q,      rdt_d;
    logic                  mem_en_q,   mem_en_d;
    logic [MEM_AW-1:0]     mem_addr_q, mem_addr_d;
    logic [LAT_CNT_W-1:0]  lat_cnt_q,  lat_cnt_d;

    logic [31:0]           adr_off;
    logic [31:0]           widx;
    logic                  out_of_range;
    logic                  buf_hit;
    logic [WB_WORD_W-1:0]  buf_data;
    logic                  buf_fill;

    // Full 32-bit range check first; truncation to MEM_AW bits only afterwards,
    // so addresses that alias into SRAM after wrap are still rejected.
    assign adr_off      = ibus.adr - BASE_ADDR;
    assign widx         = adr_off >> 2;
    assign out_of_range = (ibus.adr < BASE_ADDR) || ((widx >> MEM_AW) != 32'd0);

`ifdef SERV_IBUS_HIT_BUF_EN
    serv_ibus_hit_buf #(
        .TAG_W (MEM_AW)
    ) u_hit_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_inval      (i_ibus_inval),
        .i_fill       (buf_fill),
        .i_fill_tag   (mem_addr_q),
        .i_fill_data  (i_mem_rdata),
        .i_lookup_tag (widx[MEM_AW-1:0]),
        .o_hit        (buf_hit),
        .o_data       (buf_data)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
    logic unused_buf;
    assign unused_buf = ^{i_ibus_inval, buf_fill};
`endif

    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdt_d      = rdt_q;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        lat_cnt_d  = lat_cnt_q;
        buf_fill   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ibus.cyc) begin
                    if (out_of_range) begin
                        state_d = RESP;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        rdt_d   = '0;
                    end else if (buf_hit) begin
                        state_d = RESP;
                        ack_d   = 1'b1;
                        rdt_d   = buf_data;
                    end else begin
                        state_d    = RD;
                        mem_addr_d = widx[MEM_AW-1:0];
                        mem_en_d   = 1'b1;
                        lat_cnt_d  = '0;
                    end
                end
            end
            RD: begin
                // mem_addr_q still holds the word index, so it doubles as fill tag.
                if (!ibus.cyc) begin
                    state_d = IDLE;
                end else if (lat_cnt_q == LAT_LAST) begin
                    state_d  = RESP;
                    ack_d    = 1'b1;
                    rdt_d    = i_mem_rdata;
                    buf_fill = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdt_q      <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            lat_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdt_q      <= rdt_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

    assign ibus.ack   = ack_q;
    assign ibus.err   = err_q;
    assign ibus.rdt   = rdt_q;
    assign o_mem_en   = mem_en_q;
    assign o_mem_addr = mem_addr_q;

endmodule

// File: tb/tb_serv_ibus_responder.sv
// tb/tb_serv_ibus_responder.sv - self-checking bench for serv_ibus_responder
module tb_serv_ibus_responder;

    localparam int          AW   = 6;
    localparam int          NW   = 64;
    localparam int          LAT  = 2;
    localparam logic [31:0] BASE = 32'h0000_0100;
`ifdef SERV_IBUS_HIT_BUF_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          inval;
    logic          o_mem_en;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   i_mem_rdata;

    serv_ibus_if ibus_if ();

    serv_ibus_responder #(
        .MEM_AW    (AW),
        .RD_LAT    (LAT),
        .BASE_ADDR (BASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ibus         (ibus_if.slave),
        .i_ibus_inval (inval),
        .o_mem_en     (o_mem_en),
        .o_mem_addr   (o_mem_addr),
        .i_mem_rdata  (i_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // SRAM model: data for a read appears only in the cycle just before the
    // edge that lies LAT edges after o_mem_en was first seen, garbage otherwise.
    logic [31:0]   mem_model [0:NW-1];
    logic          pe_q [0:3];
    logic [AW-1:0] pa_q [0:3];
    logic          rd_v;
    logic [AW-1:0] rd_a;

    always_ff @(posedge clk) begin
        pe_q[0] <= 1'b0;
        pa_q[0] <= '0;
        pe_q[1] <= o_mem_en;
        pa_q[1] <= o_mem_addr;
        for (int i = 2; i < 4; i++) begin
            pe_q[i] <= pe_q[i-1];
            pa_q[i] <= pa_q[i-1];
        end
    end

    always_comb begin
        if (LAT == 1) begin
            rd_v = o_mem_en;
            rd_a = o_mem_addr;
        end else begin
            rd_v = pe_q[(LAT > 1) ? LAT - 1 : 1];
            rd_a = pa_q[(LAT > 1) ? LAT - 1 : 1];
        end
        i_mem_rdata = rd_v ? mem_model[rd_a] : 32'h0BAD_F00D;
    end

    // Reference hit buffer, tracked at request level.
    bit          bv;
    logic [31:0] btag;
    logic [31:0] bdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; entered and left at a negedge. keep=1 holds cyc high and
    // moves to next_adr right after the ack, like the aligner does.
    task automatic fetch(input logic [31:0] adr, input bit keep,
                         input logic [31:0] next_adr, input bit inval_fill);
        logic [31:0]   widx;
        bit            oor, hit, miss, do_inv;
        int            exp_lat, ack_k, en_cnt, en_k, k;
        logic [31:0]   exp_rdt, got_rdt;
        logic          exp_err, got_err;
        logic [AW-1:0] en_addr;

        widx = (adr - BASE) >> 2;
        oor  = (adr < BASE) || (widx >= NW);
        hit  = HB && !oor && bv && (btag == widx);
        miss = !oor && !hit;
        if (oor) begin
            exp_lat = 1; exp_rdt = 32'h0; exp_err = 1'b1;
        end else if (hit) begin
            exp_lat = 1; exp_rdt = bdata; exp_err = 1'b0;
        end else begin
            exp_lat = 1 + LAT; exp_rdt = mem_model[widx]; exp_err = 1'b0;
        end
        do_inv = inval_fill && miss;

        ibus_if.cyc = 1'b1;
        ibus_if.adr = adr;
        ack_k = 0; en_cnt = 0; en_k = 0; k = 0;
        got_rdt = 'x; got_err = 1'bx; en_addr = 'x;
        while (ack_k == 0 && k < 16) begin
            @(posedge clk); #1;
            k++;
            inval = do_inv && (k == LAT);
            if (o_mem_en) begin
                en_cnt++; en_k = k; en_addr = o_mem_addr;
            end
            if (ibus_if.ack) begin
                ack_k = k; got_rdt = ibus_if.rdt; got_err = ibus_if.err;
            end
        end
        inval = 1'b0;

        chk("ack_latency", 32'(ack_k), 32'(exp_lat));
        chk("rdt", got_rdt, exp_rdt);
        chk("err", {31'd0, got_err}, {31'd0, exp_err});
        chk("mem_en_pulses", 32'(en_cnt), miss ? 32'd1 : 32'd0);
        if (miss) begin
            chk("mem_en_cycle", 32'(en_k), 32'd1);
            chk("mem_addr", {26'd0, en_addr}, {26'd0, widx[AW-1:0]});
        end

        if (miss && do_inv)
            bv = 1'b0;
        else if (miss && HB) begin
            bv = 1'b1; btag = widx; bdata = mem_model[widx];
        end

        @(negedge clk);
        if (keep) ibus_if.adr = next_adr;
        else      ibus_if.cyc = 1'b0;
        @(posedge clk); #1;
        chk("ack_no_repeat", {31'd0, ibus_if.ack}, 32'd0);
        @(negedge clk);
    endtask

    // Request that is abandoned while the SRAM read is outstanding.
    task automatic fetch_abort(input logic [31:0] adr);
        int acks;
        ibus_if.cyc = 1'b1;
        ibus_if.adr = adr;
        @(posedge clk); #1;
        chk("abort_mem_en", {31'd0, o_mem_en}, 32'd1);
        @(negedge clk);
        ibus_if.cyc = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ibus_if.ack) acks++;
        end
        chk("abort_no_ack", 32'(acks), 32'd0);
        @(negedge clk);
    endtask

    task automatic idle_inval();
        inval = 1'b1;
        @(posedge clk); #1;
        inval = 1'b0;
        bv = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_adr(input logic [31:0] cur);
        int r;
        r = $urandom_range(0, 9);
        if (r < 2)       return cur;
        else if (r == 2) return BASE + 32'd256 + ($urandom_range(0, 255) << 2);
        else if (r == 3) return 32'($urandom_range(0, 255));
        else if (r == 4) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else             return BASE + ($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [31:0] cur, nxt;
        bit          keep, inv;
        int          acks;

        rst_n = 1'b0; inval = 1'b0;
        ibus_if.cyc = 1'b0; ibus_if.adr = 32'h0;
        bv = 1'b0; btag = '0; bdata = '0;
        for (int i = 0; i < NW; i++) mem_model[i] = $urandom;
        mem_model[4] = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", {31'd0, ibus_if.ack}, 32'd0);
        chk("reset_err", {31'd0, ibus_if.err}, 32'd0);
        chk("reset_mem_en", {31'd0, o_mem_en}, 32'd0);
        chk("reset_rdt", ibus_if.rdt, 32'd0);
        chk("reset_mem_addr", {26'd0, o_mem_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain miss, word 4
        fetch(BASE + 32'h10, 1'b0, 32'h0, 1'b0);

        // Aligner pattern: 0x20, then adr+4 with cyc held, then adr+4 again
        fetch(BASE + 32'h20, 1'b1, BASE + 32'h24, 1'b0);
        fetch(BASE + 32'h24, 1'b1, BASE + 32'h24, 1'b0);
        fetch(BASE + 32'h24, 1'b0, 32'h0, 1'b0);

        // Range boundaries
        fetch(BASE + 32'(4 * NW), 1'b0, 32'h0, 1'b0);
        fetch(BASE - 32'd4, 1'b0, 32'h0, 1'b0);
        fetch(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
        fetch(BASE + 32'(4 * (NW - 1)), 1'b0, 32'h0, 1'b0);
        fetch(BASE + 32'h3, 1'b0, 32'h0, 1'b0);

        // Abort during RD, then the same address must read SRAM again
        idle_inval();
        fetch_abort(BASE + 32'h30);
        fetch(BASE + 32'h30, 1'b0, 32'h0, 1'b0);

        // Invalidate on the fill edge, then refetch twice
        fetch(BASE + 32'h8, 1'b0, 32'h0, 1'b1);
        fetch(BASE + 32'h8, 1'b0, 32'h0, 1'b0);
        fetch(BASE + 32'h8, 1'b0, 32'h0, 1'b0);

        // Reset asserted asynchronously while a read is outstanding
        ibus_if.cyc = 1'b1;
        ibus_if.adr = BASE + 32'h44;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrd_ack", {31'd0, ibus_if.ack}, 32'd0);
        chk("midrd_err", {31'd0, ibus_if.err}, 32'd0);
        chk("midrd_mem_en", {31'd0, o_mem_en}, 32'd0);
        chk("midrd_rdt", ibus_if.rdt, 32'd0);
        chk("midrd_mem_addr", {26'd0, o_mem_addr}, 32'd0);
        ibus_if.cyc = 1'b0;
        bv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ibus_if.ack) acks++;
        end
        chk("midrd_no_ack", 32'(acks), 32'd0);
        @(negedge clk);
        fetch(BASE + 32'h44, 1'b0, 32'h0, 1'b0);

        // Randomized traffic
        cur = BASE + 32'h40;
        for (int it = 0; it < 80; it++) begin
            nxt  = pick_adr(cur);
            keep = 1'($urandom_range(0, 1));
            inv  = ($urandom_range(0, 5) == 0);
            fetch(cur, keep, nxt, inv);
            if (!keep && $urandom_range(0, 3) == 0) idle_inval();
            cur = nxt;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
